// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//
// Issue/retire controller that sits in front of the iterative divider core in
// the execute stage. It accepts one DIV/DIVU/REM/REMU request at a time and
// launches the core. It keeps the pipeline stalled while the core iterates. It
// resolves the RISC-V special cases (divide by zero and signed overflow) and
// hands the result back over a valid/ready interface.
//
// Optional feature macro: DIV_SPECIAL_BYPASS_EN
//   defined     : special-case requests never touch the core. The controller
//                 goes IDLE -> RESP, and resp_valid rises one cycle after accept.
//   not defined : every request runs the full START/WAIT sequence. The
//                 special-case value replaces the core result at the sample
//                 cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop the in-flight request (mispredict / trap)
//   req_valid/ready     request handshake (ready only while IDLE)
//   req_op              ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU (others ignored)
//   req_rs1, req_rs2    dividend, divisor
//   req_rd              destination register index
//   core_op             request op for the single START cycle, else ALU_ADD
//   core_left/right     latched dividend/divisor driven to the core
//   core_div_u/rem_u/div_s/rem_s   core results (final DIV_LATENCY cycles
//                                  after the start cycle)
//   stall               high whenever the controller is not IDLE
//   resp_valid/ready    response handshake
//   resp_data, resp_rd  result and its destination register
// -----------------------------------------------------------------------------
package div_ctrl_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_t;
endpackage

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 32,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  alu_op_t         req_op,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output alu_op_t         core_op,
  output logic [31:0]     core_left,
  output logic [31:0]     core_right,
  input  logic [31:0]     core_div_u,
  input  logic [31:0]     core_rem_u,
  input  logic [31:0]     core_div_s,
  input  logic [31:0]     core_rem_s,
  output logic            stall,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [RD_W-1:0] resp_rd
);

  localparam int              CNT_W    = $clog2(DIV_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  alu_op_t           op_q, op_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_next;
  logic              cnt_done;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Signed overflow only applies to the signed flavours with
  // -2^31 / -1.
  function automatic logic is_special(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic ovf;
    ovf = ((op == ALU_DIV) || (op == ALU_REM)) &&
          (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (b == 32'h0) || ovf;
  endfunction

  // Divide by zero gives all ones for quotients and the dividend for remainders.
  // Signed overflow gives the dividend as the quotient and zero as the remainder.
  function automatic logic [31:0] special_val(input alu_op_t op, input logic [31:0] a,
                                              input logic [31:0] b);
    if (b == 32'h0) begin
      return ((op == ALU_DIV) || (op == ALU_DIVU)) ? 32'hFFFF_FFFF : a;
    end
    return (op == ALU_DIV) ? 32'h8000_0000 : 32'h0;
  endfunction

  function automatic logic [31:0] core_pick(input alu_op_t op, input logic [31:0] du,
                                            input logic [31:0] ru, input logic [31:0] ds,
                                            input logic [31:0] rs);
    logic [31:0] r;
    unique case (op)
      ALU_DIVU: r = du;
      ALU_REMU: r = ru;
      ALU_DIV:  r = ds;
      default:  r = rs;
    endcase
    return r;
  endfunction

  // The iteration counter saturates at its last value, so it cannot wrap
  // even if a state lingers.
  assign cnt_done = (cnt_q == CNT_LAST);
  assign cnt_next = cnt_done ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic. The counter clears by default and only runs in
  // WAIT/DRAIN. DRAIN keeps the same count so it ends on the exact cycle the
  // core would have finished.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    data_d  = data_q;
    cnt_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush && is_div_op(req_op)) begin
          op_d  = req_op;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          rd_d  = req_rd;
`ifdef DIV_SPECIAL_BYPASS_EN
          if (is_special(req_op, req_rs1, req_rs2)) begin
            data_d  = special_val(req_op, req_rs1, req_rs2);
            state_d = RESP;
          end else begin
            state_d = START;
          end
`else
          state_d = START;
`endif
        end
      end

      START: begin
        state_d = flush ? DRAIN : WAIT;
      end

      WAIT: begin
        cnt_d = cnt_next;
        if (cnt_done) begin
          // A flush on the final cycle simply drops the result. The core is
          // already finished, so no drain is needed.
          if (flush) begin
            state_d = IDLE;
          end else begin
            data_d  = is_special(op_q, rs1_q, rs2_q)
                    ? special_val(op_q, rs1_q, rs2_q)
                    : core_pick(op_q, core_div_u, core_rem_u, core_div_s, core_rem_s);
            state_d = RESP;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        cnt_d = cnt_next;
        if (cnt_done) begin
          state_d = IDLE;
        end
      end

      RESP: begin
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset brings everything back to an idle
  // controller with a cleared response, even in the middle of an operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= ALU_ADD;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // The core only sees a real opcode during the single START cycle. The
  // operands are simply the latched request, which stays stable until the
  // next accept.
  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;
  assign core_op    = (state_q == START) ? op_q : ALU_ADD;
  assign core_left  = rs1_q;
  assign core_right = rs2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//
// Self-checking bench for div_ctrl. A timing-accurate divider-core model
// drives garbage until DIV_LATENCY cycles after the start cycle. It also
// drives garbage for operand pairs the controller must resolve itself.
// Expected results come from a 64-bit arithmetic reference of the RISC-V
// division rules.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int LAT     = 32;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  alu_op_t         req_op;
  logic [31:0]     req_rs1;
  logic [31:0]     req_rs2;
  logic [RD_W-1:0] req_rd;
  alu_op_t         core_op;
  logic [31:0]     core_left;
  logic [31:0]     core_right;
  logic [31:0]     core_div_u;
  logic [31:0]     core_rem_u;
  logic [31:0]     core_div_s;
  logic [31:0]     core_rem_s;
  logic            stall;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [RD_W-1:0] resp_rd;

  int checks = 0;
  int errors = 0;
  int core_age = 0;

  typedef struct {
    int              lat;
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    bit              stall_ok;
    bit              hold_ok;
    int              core_op_cycles;
    alu_op_t         core_op_val;
    bit              ops_ok;
    bit              idle_after;
    bit              timed_out;
  } obs_t;

  // Directed cases with hand-computed results
  alu_op_t     dir_op   [8] = '{ALU_DIVU, ALU_REM, ALU_DIV, ALU_DIV, ALU_REMU, ALU_DIV, ALU_REM, ALU_DIVU};
  logic [31:0] dir_a    [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b    [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_exp  [8] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'h0};
  int          dir_wait [8] = '{0, 5, 1, 0, 2, 0, 0, 3};

  always #5 clk = ~clk;

  div_ctrl #(.DIV_LATENCY(LAT), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .core_op    (core_op),
    .core_left  (core_left),
    .core_right (core_right),
    .core_div_u (core_div_u),
    .core_rem_u (core_rem_u),
    .core_div_s (core_div_s),
    .core_rem_s (core_rem_s),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd)
  );

  // Core model: age counts cycles since the start cycle (1 in the cycle
  // after core_op was presented).
  always @(posedge clk) begin
    if (core_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) core_age <= 1;
    else if (core_age < 10000) core_age <= core_age + 1;
  end

  // Results are final only from cycle LAT on. The model gives junk for
  // divide by zero and signed overflow, which the controller must
  // substitute itself.
  always_comb begin
    core_div_u = 32'h5A5A_5A5A;
    core_rem_u = 32'hA5A5_A5A5;
    core_div_s = 32'h3C3C_3C3C;
    core_rem_s = 32'hC3C3_C3C3;
    if (core_age >= LAT && core_right != 32'h0) begin
      core_div_u = core_left / core_right;
      core_rem_u = core_left % core_right;
      if (!(core_left == 32'h8000_0000 && core_right == 32'hFFFF_FFFF)) begin
        core_div_s = $signed(core_left) / $signed(core_right);
        core_rem_s = $signed(core_left) % $signed(core_right);
      end
    end
  end

  // Reference: RISC-V division rules in 64-bit arithmetic. Overflow falls
  // out of truncation naturally.
  function automatic logic [31:0] ref_result(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      ALU_DIVU: q = (ub == 0) ? -64'sd1 : ua / ub;
      ALU_REMU: q = (ub == 0) ? ua : ua % ub;
      ALU_DIV:  q = (sb == 0) ? -64'sd1 : sa / sb;
      ALU_REM:  q = (sb == 0) ? sa : sa % sb;
      default:  q = 0;
    endcase
    return q[31:0];
  endfunction

  // Cycles from the accept cycle to the first cycle resp_valid is seen
  function automatic int exp_latency(input alu_op_t op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit special;
    bit bypass;
    special = (b == 32'h0) ||
              ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    bypass  = 1'b0;
`ifdef DIV_SPECIAL_BYPASS_EN
    bypass  = 1'b1;
`endif
    return (special && bypass) ? 1 : LAT + 2;
  endfunction

  // Drives one request, follows it through to the response handshake and
  // records what was observed. This task does not compare anything.
  task automatic apply_stimulus(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                input logic [RD_W-1:0] rd, input int ready_delay, output obs_t obs);
    obs.lat = 0; obs.data = '0; obs.rd = '0; obs.stall_ok = 1; obs.hold_ok = 1;
    obs.core_op_cycles = 0; obs.core_op_val = ALU_ADD; obs.ops_ok = 1;
    obs.idle_after = 0; obs.timed_out = 0;
    req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd; resp_ready = 0;
    @(negedge clk);
    req_valid = 0; req_op = ALU_ADD; req_rs1 = $urandom; req_rs2 = $urandom; req_rd = RD_W'($urandom);
    obs.lat = 1;
    while (!resp_valid && obs.lat < TIMEOUT) begin
      if (!stall) obs.stall_ok = 0;
      if (core_op != ALU_ADD) begin
        obs.core_op_cycles++;
        obs.core_op_val = core_op;
      end
      if (core_left !== a || core_right !== b) obs.ops_ok = 0;
      @(negedge clk);
      obs.lat++;
    end
    if (!resp_valid) begin
      obs.timed_out = 1;
      return;
    end
    obs.data = resp_data;
    obs.rd   = resp_rd;
    if (!stall) obs.stall_ok = 0;
    for (int i = 0; i < ready_delay; i++) begin
      req_valid = 1; req_op = ALU_DIVU; req_rs1 = $urandom; req_rs2 = $urandom;
      @(negedge clk);
      if (!resp_valid || resp_data !== obs.data || resp_rd !== obs.rd || req_ready) obs.hold_ok = 0;
    end
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    obs.idle_after = req_ready && !resp_valid && !stall;
  endtask

  // Reset state, both while reset is held and after it is released
  task automatic test_reset();
    rst = 1; flush = 0; req_valid = 0; req_op = ALU_ADD; req_rs1 = 0; req_rs2 = 0;
    req_rd = 0; resp_ready = 0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset.req_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset.resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset.resp_data got %h want 0", resp_data); end
    checks++; if (resp_rd !== '0) begin errors++; $display("[TB] FAIL reset.resp_rd got %0d want 0", resp_rd); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset.stall got %b want 0", stall); end
    checks++; if (core_op !== ALU_ADD) begin errors++; $display("[TB] FAIL reset.core_op got %s want ALU_ADD", core_op.name()); end
    rst = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL reset.release ready=%b stall=%b want 1/0", req_ready, stall); end
  endtask

  // Known-answer cases, including resp_ready held low in RESP
  task automatic test_directed();
    obs_t o;
    for (int i = 0; i < 8; i++) begin
      logic [RD_W-1:0] rd;
      int exp_cyc;
      rd = RD_W'(i * 3 + 1);
      exp_cyc = (exp_latency(dir_op[i], dir_a[i], dir_b[i]) == 1) ? 0 : 1;
      apply_stimulus(dir_op[i], dir_a[i], dir_b[i], rd, dir_wait[i], o);
      checks++; if (o.timed_out) begin errors++; $display("[TB] FAIL dir%0d.timeout no resp_valid within %0d cycles", i, TIMEOUT); end
      checks++; if (o.data !== dir_exp[i]) begin errors++; $display("[TB] FAIL dir%0d.data %s got %h want %h", i, dir_op[i].name(), o.data, dir_exp[i]); end
      checks++; if (o.rd !== rd) begin errors++; $display("[TB] FAIL dir%0d.rd got %0d want %0d", i, o.rd, rd); end
      checks++; if (o.lat != exp_latency(dir_op[i], dir_a[i], dir_b[i])) begin errors++; $display("[TB] FAIL dir%0d.latency got %0d want %0d", i, o.lat, exp_latency(dir_op[i], dir_a[i], dir_b[i])); end
      checks++; if (!o.stall_ok) begin errors++; $display("[TB] FAIL dir%0d.stall got low while busy want high", i); end
      checks++; if (!o.hold_ok) begin errors++; $display("[TB] FAIL dir%0d.hold response changed or request accepted during backpressure", i); end
      checks++; if (o.core_op_cycles != exp_cyc) begin errors++; $display("[TB] FAIL dir%0d.core_op_cycles got %0d want %0d", i, o.core_op_cycles, exp_cyc); end
      if (exp_cyc == 1) begin
        checks++; if (o.core_op_val !== dir_op[i]) begin errors++; $display("[TB] FAIL dir%0d.core_op got %s want %s", i, o.core_op_val.name(), dir_op[i].name()); end
        checks++; if (!o.ops_ok) begin errors++; $display("[TB] FAIL dir%0d.core_operands not held at %h/%h", i, dir_a[i], dir_b[i]); end
      end
      checks++; if (!o.idle_after) begin errors++; $display("[TB] FAIL dir%0d.idle_after got busy want idle", i); end
    end
  endtask

  // Non-division ops are ignored, and the controller stays ready
  task automatic test_non_div();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_op = alu_op_t'(4'($urandom_range(0, 10)));
      req_rs1 = $urandom; req_rs2 = $urandom;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || req_ready !== 1'b1 || core_op !== ALU_ADD) begin
        errors++;
        $display("[TB] FAIL non_div.ignore stall=%b ready=%b core_op=%s want 0/1/ALU_ADD", stall, req_ready, core_op.name());
      end
    end
    req_valid = 0;
  endtask

  // Flush in WAIT, START, RESP and IDLE
  task automatic test_flush();
    int k;
    bit seen;
    // Flush at WAIT count 10. START is seen at k=1 and count c at k=c+2.
    req_valid = 1; req_op = ALU_DIV; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd9;
    @(negedge clk); req_valid = 0; k = 1;
    while (k < 12) begin @(negedge clk); k++; end
    flush = 1; @(negedge clk); k++; flush = 0;
    seen = 0;
    while (stall && k < TIMEOUT) begin if (resp_valid) seen = 1; @(negedge clk); k++; end
    checks++; if (seen) begin errors++; $display("[TB] FAIL flush_wait.resp_valid got 1 want 0"); end
    checks++; if (k != LAT + 2) begin errors++; $display("[TB] FAIL flush_wait.drain_end got %0d want %0d", k, LAT + 2); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait.idle ready=%b valid=%b want 1/0", req_ready, resp_valid); end

    // Flush during START still launches the core and drains the full latency.
    req_valid = 1; req_op = ALU_REMU; req_rs1 = 32'd77; req_rs2 = 32'd5; req_rd = 5'd3;
    @(negedge clk); req_valid = 0; k = 1;
    checks++; if (core_op !== ALU_REMU) begin errors++; $display("[TB] FAIL flush_start.core_op got %s want ALU_REMU", core_op.name()); end
    flush = 1; @(negedge clk); k++; flush = 0;
    seen = 0;
    while (stall && k < TIMEOUT) begin if (resp_valid) seen = 1; @(negedge clk); k++; end
    checks++; if (seen) begin errors++; $display("[TB] FAIL flush_start.resp_valid got 1 want 0"); end
    checks++; if (k != LAT + 2) begin errors++; $display("[TB] FAIL flush_start.drain_end got %0d want %0d", k, LAT + 2); end

    // Flush while the result waits in RESP drops it
    req_valid = 1; req_op = ALU_DIV; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd4;
    @(negedge clk); req_valid = 0; k = 1;
    while (!resp_valid && k < TIMEOUT) begin @(negedge clk); k++; end
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd333) begin errors++; $display("[TB] FAIL flush_resp.result valid=%b data=%h want 1/%h", resp_valid, resp_data, 32'd333); end
    flush = 1; @(negedge clk); flush = 0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_resp.drop valid=%b ready=%b want 0/1", resp_valid, req_ready); end

    // Flush in IDLE blocks acceptance that cycle
    req_valid = 1; req_op = ALU_DIVU; req_rs1 = 32'd50; req_rs2 = 32'd5; flush = 1;
    @(negedge clk); req_valid = 0; flush = 0;
    checks++; if (stall !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle.accept stall=%b ready=%b want 0/1", stall, req_ready); end
  endtask

  // Reset (together with flush) in the middle of WAIT
  task automatic test_reset_mid();
    obs_t o;
    bit seen;
    req_valid = 1; req_op = ALU_DIVU; req_rs1 = 32'd999; req_rs2 = 32'd4; req_rd = 5'd17;
    @(negedge clk); req_valid = 0;
    repeat (9) @(negedge clk);
    rst = 1; flush = 1;
    @(negedge clk);
    rst = 0; flush = 0;
    checks++; if (stall !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid.state stall=%b ready=%b want 0/1", stall, req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_rd !== '0) begin errors++; $display("[TB] FAIL reset_mid.resp valid=%b data=%h rd=%0d want 0/0/0", resp_valid, resp_data, resp_rd); end
    checks++; if (core_op !== ALU_ADD) begin errors++; $display("[TB] FAIL reset_mid.core_op got %s want ALU_ADD", core_op.name()); end
    seen = 0;
    repeat (LAT + 4) begin @(negedge clk); if (resp_valid || stall) seen = 1; end
    checks++; if (seen) begin errors++; $display("[TB] FAIL reset_mid.quiet got activity after reset want none"); end
    apply_stimulus(ALU_DIVU, 32'd999, 32'd4, 5'd17, 0, o);
    checks++; if (o.data !== 32'd249 || o.rd !== 5'd17) begin errors++; $display("[TB] FAIL reset_mid.recover data=%h rd=%0d want %h/17", o.data, o.rd, 32'd249); end
  endtask

  // Requests issued right on the idle cycle after each response
  task automatic test_back_to_back();
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom_range(1, 1000);
      apply_stimulus(ALU_REMU, a, b, RD_W'(i + 20), 0, o);
      checks++; if (o.data !== ref_result(ALU_REMU, a, b) || o.lat != LAT + 2 || !o.idle_after) begin
        errors++; $display("[TB] FAIL b2b%0d.txn data=%h lat=%0d idle=%b want %h/%0d/1", i, o.data, o.lat, o.idle_after, ref_result(ALU_REMU, a, b), LAT + 2);
      end
    end
  endtask

  // Random ops against the reference model, biased toward special operands
  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 40; n++) begin
      alu_op_t op;
      logic [31:0] a, b, exp;
      logic [RD_W-1:0] rd;
      case ($urandom_range(0, 3))
        0: op = ALU_DIV;
        1: op = ALU_DIVU;
        2: op = ALU_REM;
        default: op = ALU_REMU;
      endcase
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      rd = RD_W'($urandom);
      exp = ref_result(op, a, b);
      apply_stimulus(op, a, b, rd, $urandom_range(0, 3), o);
      checks++; if (o.timed_out) begin errors++; $display("[TB] FAIL rnd%0d.timeout no resp_valid", n); end
      checks++; if (o.data !== exp) begin errors++; $display("[TB] FAIL rnd%0d.data %s %h,%h got %h want %h", n, op.name(), a, b, o.data, exp); end
      checks++; if (o.rd !== rd) begin errors++; $display("[TB] FAIL rnd%0d.rd got %0d want %0d", n, o.rd, rd); end
      checks++; if (o.lat != exp_latency(op, a, b)) begin errors++; $display("[TB] FAIL rnd%0d.latency got %0d want %0d", n, o.lat, exp_latency(op, a, b)); end
      checks++; if (!o.stall_ok || !o.hold_ok || !o.idle_after) begin errors++; $display("[TB] FAIL rnd%0d.handshake stall_ok=%b hold_ok=%b idle=%b want 1/1/1", n, o.stall_ok, o.hold_ok, o.idle_after); end
    end
  endtask

  initial begin
    $display("[TB] div_ctrl bench start, DIV_LATENCY=%0d", LAT);
    test_reset();
    test_directed();
    test_non_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a wedged design still ends the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
